// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Receives a byte stream (16-bit little-endian word-count header,
//            then instruction bytes), assembles little-endian 32-bit words and
//            writes them to instruction memory. Holds the CPU in reset until
//            the whole image has been written.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_adr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words_written
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  // One extra bit so the capacity compares cleanly against any header value.
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(DEPTH_WORDS);

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_n_words;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_wbuf;

  logic             w_accept;
  logic [CNT_W-1:0] w_len;
  logic             w_len_bad;
  logic [CNT_W-1:0] w_ww_inc;

  assign w_accept  = in_valid & in_ready;
  assign w_len     = CNT_W'({in_data, r_n_words[7:0]});
  assign w_len_bad = (w_len == '0) || ({1'b0, w_len} > C_DEPTH);
  assign w_ww_inc  = words_written + CNT_W'(1);

  // Next-state selection; outputs are registered from this next state.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_state_n = S_LEN0;
      S_LEN0:  if (w_accept) w_state_n = S_LEN1;
      S_LEN1:  if (w_accept) w_state_n = w_len_bad ? S_ERROR : S_DATA;
      S_DATA:  if (w_accept && (r_byte_idx == 2'd3)) w_state_n = S_WRITE;
      S_WRITE: w_state_n = (w_ww_inc == r_n_words) ? S_DONE : S_DATA;
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register, registered status outputs and word assembly datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      in_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_adr      <= '0;
      imem_wdata    <= '0;
      cpu_rst       <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
      r_n_words     <= '0;
      r_byte_idx    <= 2'd0;
      r_wbuf        <= '0;
    end else begin
      r_state  <= w_state_n;
      in_ready <= (w_state_n == S_LEN0) || (w_state_n == S_LEN1) || (w_state_n == S_DATA);
      busy     <= (w_state_n == S_LEN0) || (w_state_n == S_LEN1) ||
                  (w_state_n == S_DATA) || (w_state_n == S_WRITE);
      imem_we  <= (w_state_n == S_WRITE);
      done     <= (w_state_n == S_DONE);
      err      <= (w_state_n == S_ERROR);
      cpu_rst  <= (w_state_n != S_DONE);

      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            words_written <= '0;
            r_byte_idx    <= 2'd0;
          end
        end
        S_LEN0: if (w_accept) r_n_words <= CNT_W'(in_data);
        S_LEN1: if (w_accept) r_n_words <= w_len;
        S_DATA: begin
          if (w_accept) begin
            if (r_byte_idx == 2'd3) begin
              // Fourth byte completes the word; capture address alongside it.
              imem_wdata <= {in_data, r_wbuf};
              imem_adr   <= ADDR_W'({words_written, 2'b00});
              r_byte_idx <= 2'd0;
            end else begin
              case (r_byte_idx)
                2'd0:    r_wbuf[7:0]   <= in_data;
                2'd1:    r_wbuf[15:8]  <= in_data;
                default: r_wbuf[23:16] <= in_data;
              endcase
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
        end
        S_WRITE: words_written <= w_ww_inc;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader: table-driven loads, a
//            full-capacity load, randomized images against a reference list of
//            expected writes, and reset/idle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 64;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_adr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] words_written;

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_adr(imem_adr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int we_cyc = -1;

  logic [AW-1:0] got_adr[$];
  logic [31:0]   got_dat[$];
  logic [31:0]   img[0:DEPTH-1];

  typedef struct {
    int          n;
    int          nsend;
    int          mode;
    bit          ok;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    ncmp++;
    nfail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Cycle counter: value seen at a falling edge names the preceding rising edge.
  always @(posedge clk) cyc++;

  // Collect every memory write and confirm the stream is paused during it.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_adr.push_back(imem_adr);
      got_dat.push_back(imem_wdata);
      we_cyc = cyc;
      chk("ready_low_in_write", 64'(in_ready), 64'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout_fail("byte_accept");
    acc_cyc = cyc;
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expected result of a load: writes (4*i, img[i]) for i<n, or an error.
  task automatic run_load(input int n, input int nsend, input int mode, input bit ok);
    int t;
    logic [15:0] hdr;
    hdr = 16'(n);
    got_adr.delete();
    got_dat.delete();
    we_cyc = -1;
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("start_words_written", 64'(words_written), 64'd0);
    send_byte(hdr[7:0], gap_for(mode));
    send_byte(hdr[15:8], gap_for(mode));
    for (int i = 0; i < nsend; i++)
      for (int k = 0; k < 4; k++)
        send_byte(img[i][8*k +: 8], gap_for(mode));
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!(done === 1'b1 || err === 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      timeout_fail("load_end");
    end else if (ok) begin
      chk("done", 64'(done), 64'd1);
      chk("err", 64'(err), 64'd0);
      chk("cpu_rst_released", 64'(cpu_rst), 64'd0);
      chk("words_written", 64'(words_written), 64'(n));
      chk("last_write_latency", 64'(we_cyc - acc_cyc), 64'd1);
      chk("done_latency", 64'(cyc - acc_cyc), 64'd2);
      chk("write_count", 64'(got_adr.size()), 64'(n));
      for (int i = 0; i < n && i < got_adr.size(); i++) begin
        chk("write_adr", got_adr[i], 64'(4 * i));
        chk("write_data", 64'(got_dat[i]), 64'(img[i]));
      end
    end else begin
      chk("err", 64'(err), 64'd1);
      chk("done", 64'(done), 64'd0);
      chk("cpu_rst_held", 64'(cpu_rst), 64'd1);
      chk("err_write_count", 64'(got_adr.size()), 64'd0);
      chk("err_latency", 64'(cyc - acc_cyc), 64'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 2,         nsend: 2, mode: 0, ok: 1'b1, w0: 32'h00500093, w1: 32'h00A00113};
    vecs[1] = '{n: 2,         nsend: 2, mode: 1, ok: 1'b1, w0: 32'h00500093, w1: 32'h00A00113};
    vecs[2] = '{n: 0,         nsend: 0, mode: 0, ok: 1'b0, w0: 32'h0,        w1: 32'h0};
    vecs[3] = '{n: DEPTH + 1, nsend: 0, mode: 0, ok: 1'b0, w0: 32'h0,        w1: 32'h0};
    vecs[4] = '{n: 2,         nsend: 2, mode: 0, ok: 1'b1, w0: 32'h00500093, w1: 32'h00A00113};
    vecs[5] = '{n: 1,         nsend: 1, mode: 2, ok: 1'b1, w0: 32'hDEADBEEF, w1: 32'h0};

    // Reset then idle.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_imem_adr", imem_adr, 64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_words_written", 64'(words_written), 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    chk("idle_no_writes", 64'(got_adr.size()), 64'd0);

    // Table-driven loads: basic, bubbles, length errors, recovery, reload.
    for (int v = 0; v < 6; v++) begin
      img[0] = vecs[v].w0;
      img[1] = vecs[v].w1;
      run_load(vecs[v].n, vecs[v].nsend, vecs[v].mode, vecs[v].ok);
    end

    // Full-capacity image reaches the top address 4*(DEPTH-1).
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    run_load(DEPTH, DEPTH, 0, 1'b1);
    if (got_adr.size() == DEPTH) chk("max_adr", got_adr[DEPTH-1], 64'(4 * (DEPTH - 1)));
    else timeout_fail("max_adr");

    // Randomized images, lengths and bubbles.
    for (int it = 0; it < 10; it++) begin
      int kind;
      int n;
      bit ok;
      kind = int'($urandom_range(0, 4));
      if (kind == 0) begin
        n = 0; ok = 1'b0;
      end else if (kind == 1) begin
        n = int'($urandom_range(DEPTH + 1, 65535)); ok = 1'b0;
      end else begin
        n = int'($urandom_range(1, 8)); ok = 1'b1;
      end
      for (int i = 0; i < 8; i++) img[i] = $urandom;
      run_load(n, ok ? n : 0, 2, ok);
    end

    // Reset in the middle of a three-word load.
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    got_adr.delete();
    got_dat.delete();
    pulse_start();
    send_byte(8'd3, 0);
    send_byte(8'd0, 0);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_words_written", 64'(words_written), 64'd1);
    pulse_start();
    chk("start_ignored_busy", 64'(busy), 64'd1);
    chk("start_ignored_ww", 64'(words_written), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("abort_words_written", 64'(words_written), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", 64'(busy), 64'd0);
    chk("abort_write_count", 64'(got_adr.size()), 64'd1);
    if (got_adr.size() >= 1) chk("abort_write_data", 64'(got_dat[0]), 64'(img[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that writes RISC-V instruction words into the instruction memory before the pipeline runs.
- The pipeline's fetch stage only reads instruction memory. This block is the writer on the same interface.
- It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues word writes.
- It holds the processor in reset until the program image has been fully written.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words.
- ADDR_W, 64, width of the byte address driven to instruction memory (matches pc width).
- CNT_W, 16, width of the word-count header and of the words_written counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_adr  output  ADDR_W  byte address of the write; always a multiple of 4.
- imem_wdata  output  32  assembled instruction word.
- cpu_rst  output  1  reset to pc and the pipeline registers.
- busy  output  1  high in LEN0, LEN1, DATA and WRITE.
- done  output  1  high in DONE.
- err  output  1  high in ERROR.
- words_written  output  CNT_W  count of words written in the current load.

Behaviour:
- Reset values (while rst=1 and in the cycle after):
  - state=IDLE.
  - in_ready=0, imem_we=0, imem_adr=0, imem_wdata=0.
  - cpu_rst=1, busy=0, done=0, err=0, words_written=0.
  - rst mid-load aborts the load. Words already written stay in memory; the loader does not clear them.
- Byte transfer: a byte is taken only on a cycle with in_valid=1 and in_ready=1. in_ready depends only on state, never on in_valid.
- States:
  - IDLE: in_ready=0. start -> LEN0; clear words_written and byte index; cpu_rst=1.
  - LEN0: in_ready=1. Accepted byte -> N[7:0]; go to LEN1.
  - LEN1: in_ready=1. Accepted byte -> N[15:8]; go to ERROR if the full N is 0 or N > DEPTH_WORDS, else DATA.
  - DATA: in_ready=1.
    - Byte k of the current word (k=0..3) goes to wdata[8k+7:8k]; little-endian.
    - On the 4th accepted byte, go to WRITE.
  - WRITE: in_ready=0; imem_we=1 for exactly this one cycle.
    - imem_adr = 4*words_written.
    - imem_wdata = the assembled word, stable for the whole cycle.
    - Next cycle: words_written increments. If the new count equals N, go to DONE; else go to DATA with byte index reset to 0.
  - DONE: done=1; cpu_rst=0 from the first DONE cycle (registered output); in_ready=0. start -> LEN0 and cpu_rst returns to 1 on the next cycle.
  - ERROR: err=1, cpu_rst=1, in_ready=0. start -> LEN0.
- start is ignored while busy=1. start in the same cycle as rst: rst wins.
- Load latency: the last word's imem_we occurs 1 cycle after its 4th byte is accepted; done rises 1 cycle after that.
- Bubbles: in_valid gaps stall the state machine with no state change and no byte loss.
- Width rules:
  - imem_adr is zero-extended to ADDR_W.
  - words_written never exceeds N, which is ≤ DEPTH_WORDS, so there is no wrap.
  - Maximum address written is 4*(DEPTH_WORDS-1).

Test Plan:
- Reset then idle: rst 2 cycles, no start -> cpu_rst=1, in_ready=0, imem_we never asserted for 20 cycles.
- Two-word load, in_valid always 1:
  - Stimulus: start; bytes 02 00 | 93 00 50 00 | 13 01 A0 00.
  - Required: imem_we at adr 0x0 with 0x00500093, then at adr 0x4 with 0x00A00113.
  - done=1, cpu_rst=0 one cycle after the second write; words_written=2.
- Back-pressure and bubbles:
  - Same image with in_valid toggled 1,0,1,0…
  - Required: identical writes; in_ready=0 on each WRITE cycle; no byte dropped or duplicated.
- Length errors:
  - Header 00 00 -> err=1, cpu_rst=1, no imem_we.
  - Header DEPTH_WORDS+1 -> same response.
  - A following start plus a valid image -> recovers to DONE.
- Reset mid-load: rst asserted after 1 of 3 words is written -> IDLE, cpu_rst=1, words_written=0; start ignored during rst.
- Reload from DONE: start -> cpu_rst=1 next cycle; second image overwrites from adr 0; done reasserts.
